dmem_arbiter: RTL and testbench

Arbiter and sequencer for the four byte-lane data memory banks behind the execute2 stage. Shares the single memory port between the CPU (absolute priority, zero added latency) and a debug/display requester using a req/ack handshake. Holds debug requests until a CPU-free cycle. If the debug side starves, it raises a stall request toward the pc and fetch/decode registers so that a CPU-free slot opens.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arbiter_starve_counter.sv | 40 ++++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Covers the arbiter state encoding, the full-word lane masks and the default starvation limit.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  localparam logic [3:0] WREN_ALL  = 4'b1111;
  localparam logic [3:0] WREN_NONE = 4'b0000;

  localparam int DEFAULT_STARVE_LIMIT = 16;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating up-counter measuring how long a debug request has been held off by the CPU.
// at_limit stays high once the count reaches LIMIT, until the next clear.
module starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic sysclk,
  input  logic cpu_reset,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != LIMIT_V)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign at_limit = (count_reg == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the execute2 data-memory port between the CPU (always wins, no added latency)
// and a req/ack debug requester that is served in CPU-free cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              sysclk,
  input  logic              cpu_reset,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_wren,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              stall_req,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_reg, state_next;
  logic              lat_we_reg;
  logic [ADDR_W-1:0] lat_addr_reg;
  logic [DATA_W-1:0] lat_wdata_reg;
  logic [DATA_W-1:0] dbg_rdata_reg;

  logic       dbg_own;
  logic       wait_clr;
  logic       wait_en;
  logic       wait_at_limit;
  logic [3:0] lat_wren;

  always_comb begin
    state_next = state_reg;
    dbg_own    = 1'b0;
    wait_clr   = 1'b0;
    wait_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dbg_req) begin
          state_next = WAIT;
          wait_clr   = 1'b1;
        end
      end
      WAIT: begin
        if (cpu_valid) begin
          wait_en = 1'b1;
        end else begin
          dbg_own    = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state_reg     <= IDLE;
      lat_we_reg    <= 1'b0;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      dbg_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && dbg_req) begin
        lat_we_reg    <= dbg_we;
        lat_addr_reg  <= dbg_addr;
        lat_wdata_reg <= dbg_wdata;
      end
      if (dbg_own && !lat_we_reg) begin
        dbg_rdata_reg <= mem_rdata;
      end
    end
  end

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_counter (
    .sysclk   (sysclk),
    .cpu_reset(cpu_reset),
    .clr      (wait_clr),
    .en       (wait_en),
    .at_limit (wait_at_limit)
  );

  // Debug writes are always full-word; reset overrides every lane so no write escapes.
  assign lat_wren = lat_we_reg ? WREN_ALL : WREN_NONE;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign mem_wren[gi] = !cpu_reset &&
                            (dbg_own ? lat_wren[gi] : (cpu_valid && cpu_wren[gi]));
    end
  endgenerate

  assign mem_addr  = dbg_own ? lat_addr_reg  : cpu_addr;
  assign mem_wdata = dbg_own ? lat_wdata_reg : cpu_wdata;
  assign cpu_rdata = mem_rdata;

  assign dbg_ack   = (state_reg == ACK);
  assign dbg_rdata = dbg_rdata_reg;
  assign busy      = (state_reg != IDLE);
  assign stall_req = (state_reg == WAIT) && wait_at_limit;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run,
// with a memory image and request-level reference model kept in the bench.
module tb_dmem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  logic              sysclk = 1'b0;
  logic              cpu_reset = 1'b1;
  logic              cpu_valid = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [3:0]        cpu_wren = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req = 1'b0;
  logic              dbg_we = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wdata = '0;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              stall_req;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .stall_req(stall_req), .busy(busy),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Four byte-lane banks driven by the DUT's memory port, asynchronous read.
  logic [7:0] bank [4][256];
  assign mem_rdata = {bank[3][mem_addr], bank[2][mem_addr], bank[1][mem_addr], bank[0][mem_addr]};
  always @(posedge sysclk) begin
    for (int l = 0; l < 4; l++)
      if (mem_wren[l]) bank[l][mem_addr] <= mem_wdata[8*l +: 8];
  end

  // Reference model: one outstanding debug request, counted CPU hold-offs,
  // and the memory image implied by CPU stores and debug accesses.
  logic [DATA_W-1:0] ref_mem [256];
  logic              m_pend = 1'b0;
  logic              m_ack = 1'b0;
  int                m_waited = 0;
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_rdata = '0;

  always @(posedge sysclk) begin
    if (cpu_reset) begin
      m_pend   <= 1'b0;
      m_ack    <= 1'b0;
      m_waited <= 0;
      m_rdata  <= '0;
    end else begin
      m_ack <= 1'b0;
      if (m_pend && !cpu_valid) begin
        if (m_we) ref_mem[m_addr] <= m_wdata;
        else      m_rdata <= ref_mem[m_addr];
        m_pend <= 1'b0;
        m_ack  <= 1'b1;
      end else begin
        if (cpu_valid)
          for (int l = 0; l < 4; l++)
            if (cpu_wren[l]) ref_mem[cpu_addr][8*l +: 8] <= cpu_wdata[8*l +: 8];
        if (m_pend) begin
          m_waited <= m_waited + 1;
        end else if (!m_ack && dbg_req) begin
          m_pend   <= 1'b1;
          m_waited <= 0;
          m_we     <= dbg_we;
          m_addr   <= dbg_addr;
          m_wdata  <= dbg_wdata;
        end
      end
    end
  end

  wire               m_own     = m_pend && !cpu_valid;
  wire [ADDR_W-1:0]  exp_addr  = m_own ? m_addr : cpu_addr;
  wire [DATA_W-1:0]  exp_wdata = m_own ? m_wdata : cpu_wdata;
  wire [3:0]         exp_wren  = cpu_reset ? 4'b0000 :
                                 m_own ? (m_we ? 4'b1111 : 4'b0000) :
                                 (cpu_valid ? cpu_wren : 4'b0000);
  wire               exp_stall = m_pend && (m_waited >= LIMIT);
  wire               exp_busy  = m_pend || m_ack;

  task automatic next_cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    cpu_reset = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 32'h1234_5678;
    cpu_valid = 1'b1; cpu_wren = 4'b1111; cpu_addr = 8'h20; cpu_wdata = 32'hCAFE_F00D;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if ({mem_wren, dbg_ack, busy, stall_req} !== 7'b0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got wren=%b ack=%b busy=%b stall=%b exp all 0",
                 k, mem_wren, dbg_ack, busy, stall_req);
      end
      checks++;
      if (dbg_rdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_dbg_rdata cyc=%0d got=%h exp=00000000", k, dbg_rdata);
      end
      $display("reset cycle %0d: wren=%b ack=%b busy=%b", k, mem_wren, dbg_ack, busy);
      next_cycle();
    end
    cpu_reset = 1'b0; dbg_req = 1'b0; cpu_valid = 1'b0; cpu_wren = 4'b0000;
    next_cycle();
  endtask

  task automatic test_idle_read();
    cpu_valid = 1'b1; cpu_addr = 8'h85; cpu_wren = 4'b1111; cpu_wdata = 32'h0000_0315;
    #2;
    checks++;
    if (mem_wren !== 4'b1111 || mem_addr !== 8'h85) begin
      failures++;
      $display("FAIL idle_read_cpu_store got addr=%h wren=%b exp addr=85 wren=1111", mem_addr, mem_wren);
    end
    next_cycle();
    cpu_valid = 1'b0; cpu_wren = 4'b0000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h85;
    next_cycle();
    #2;
    checks++;
    if (busy !== 1'b1 || mem_addr !== 8'h85 || mem_wren !== 4'b0000 || dbg_ack !== 1'b0) begin
      failures++;
      $display("FAIL idle_read_access got busy=%b addr=%h wren=%b ack=%b exp 1/85/0000/0",
               busy, mem_addr, mem_wren, dbg_ack);
    end
    next_cycle();
    dbg_req = 1'b0;
    #2;
    checks++;
    if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h0000_0315 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_read_ack got ack=%b rdata=%h stall=%b exp 1/00000315/0", dbg_ack, dbg_rdata, stall_req);
    end
    $display("idle read: ack=%b rdata=%h", dbg_ack, dbg_rdata);
    next_cycle();
    #2;
    checks++;
    if (dbg_ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_read_after got ack=%b busy=%b exp 0/0", dbg_ack, busy);
    end
    next_cycle();
  endtask

  logic [DATA_W-1:0] coll_data;

  task automatic test_collision();
    coll_data = $urandom;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = coll_data;
    cpu_valid = 1'b0; cpu_wren = 4'($urandom); cpu_addr = 8'h07;
    #2;
    checks++;
    if (mem_wren !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL collision_cyc0 got wren=%b busy=%b exp 0000/0", mem_wren, busy);
    end
    next_cycle();
    for (int k = 1; k <= 5; k++) begin
      cpu_valid = 1'b1; cpu_addr = 8'($urandom_range(0, 15));
      cpu_wren = 4'($urandom); cpu_wdata = $urandom;
      #2;
      checks++;
      if (mem_addr !== cpu_addr || mem_wren !== cpu_wren || mem_wdata !== cpu_wdata || dbg_ack !== 1'b0) begin
        failures++;
        $display("FAIL collision_cpu cyc=%0d got addr=%h wren=%b wdata=%h ack=%b exp %h/%b/%h/0",
                 k, mem_addr, mem_wren, mem_wdata, dbg_ack, cpu_addr, cpu_wren, cpu_wdata);
      end
      checks++;
      if (stall_req !== (k >= 5)) begin
        failures++;
        $display("FAIL collision_stall cyc=%0d got=%b exp=%b", k, stall_req, k >= 5);
      end
      next_cycle();
    end
    cpu_valid = 1'b0;
    #2;
    checks++;
    if (mem_addr !== 8'h40 || mem_wren !== 4'b1111 || mem_wdata !== coll_data) begin
      failures++;
      $display("FAIL collision_dbg_access got addr=%h wren=%b wdata=%h exp 40/1111/%h",
               mem_addr, mem_wren, mem_wdata, coll_data);
    end
    next_cycle();
    dbg_req = 1'b0;
    #2;
    checks++;
    if (dbg_ack !== 1'b1 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL collision_ack got ack=%b stall=%b exp 1/0", dbg_ack, stall_req);
    end
    $display("collision: ack=%b in cycle 7", dbg_ack);
    next_cycle();
  endtask

  task automatic test_starvation();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h40;
    cpu_valid = 1'b0;
    next_cycle();
    for (int k = 1; k <= 6; k++) begin
      cpu_valid = 1'b1; cpu_wren = 4'b0000; cpu_addr = 8'($urandom_range(0, 15));
      #2;
      checks++;
      if (stall_req !== (k >= 5) || dbg_ack !== 1'b0) begin
        failures++;
        $display("FAIL starve_stall cyc=%0d got stall=%b ack=%b exp %b/0", k, stall_req, dbg_ack, k >= 5);
      end
      next_cycle();
    end
    cpu_valid = 1'b0;
    #2;
    checks++;
    if (stall_req !== 1'b1 || mem_addr !== 8'h40 || mem_wren !== 4'b0000) begin
      failures++;
      $display("FAIL starve_access got stall=%b addr=%h wren=%b exp 1/40/0000", stall_req, mem_addr, mem_wren);
    end
    next_cycle();
    dbg_req = 1'b0;
    #2;
    checks++;
    if (dbg_ack !== 1'b1 || stall_req !== 1'b0 || dbg_rdata !== coll_data || dbg_rdata !== m_rdata) begin
      failures++;
      $display("FAIL starve_ack got ack=%b stall=%b rdata=%h exp 1/0/%h", dbg_ack, stall_req, dbg_rdata, coll_data);
    end
    $display("starvation: ack=%b rdata=%h", dbg_ack, dbg_rdata);
    next_cycle();
    #2;
    checks++;
    if (stall_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL starve_after got stall=%b busy=%b exp 0/0", stall_req, busy);
    end
    next_cycle();
  endtask

  task automatic test_dbg_write();
    int n_full = 0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h90; dbg_wdata = 32'h0000_03DB;
    cpu_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) dbg_req = 1'b0;
      #2;
      if (mem_wren === 4'b1111) n_full++;
      if (k == 2) begin
        checks++;
        if (dbg_ack !== 1'b1) begin
          failures++;
          $display("FAIL dbg_write_ack got=%b exp=1", dbg_ack);
        end
      end
      next_cycle();
    end
    checks++;
    if (n_full != 1) begin
      failures++;
      $display("FAIL dbg_write_wren_cycles got=%0d exp=1", n_full);
    end
    cpu_valid = 1'b1; cpu_wren = 4'b0000; cpu_addr = 8'h90;
    #2;
    checks++;
    if (cpu_rdata !== 32'h0000_03DB || mem_wren !== 4'b0000) begin
      failures++;
      $display("FAIL dbg_write_readback got rdata=%h wren=%b exp 000003db/0000", cpu_rdata, mem_wren);
    end
    $display("debug write: full-word cycles=%0d readback=%h", n_full, cpu_rdata);
    next_cycle();
    cpu_valid = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    cpu_valid = 1'b1; cpu_addr = 8'h33; cpu_wren = 4'b1111; cpu_wdata = 32'hA5A5_0001;
    next_cycle();
    cpu_valid = 1'b0; cpu_wren = 4'b0000;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h33; dbg_wdata = 32'hDEAD_BEEF;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      cpu_valid = 1'b1; cpu_addr = 8'h01;
      #2;
      checks++;
      if (busy !== 1'b1 || mem_wren !== 4'b0000) begin
        failures++;
        $display("FAIL midwait_pending cyc=%0d got busy=%b wren=%b exp 1/0000", k, busy, mem_wren);
      end
      next_cycle();
    end
    cpu_reset = 1'b1; cpu_valid = 1'b0;
    #2;
    checks++;
    if (mem_wren !== 4'b0000) begin
      failures++;
      $display("FAIL midwait_reset_wren got=%b exp=0000", mem_wren);
    end
    next_cycle();
    cpu_reset = 1'b0; dbg_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (dbg_ack !== 1'b0 || busy !== 1'b0 || mem_wren !== 4'b0000 || dbg_rdata !== 32'h0) begin
        failures++;
        $display("FAIL midwait_after cyc=%0d got ack=%b busy=%b wren=%b rdata=%h exp 0/0/0000/0",
                 k, dbg_ack, busy, mem_wren, dbg_rdata);
      end
      next_cycle();
    end
    cpu_valid = 1'b1; cpu_addr = 8'h33; cpu_wren = 4'b0000;
    #2;
    checks++;
    if (cpu_rdata !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL midwait_mem got=%h exp=a5a50001", cpu_rdata);
    end
    $display("reset mid-wait: mem[33]=%h", cpu_rdata);
    next_cycle();
    cpu_valid = 1'b0;
  endtask

  task automatic test_random();
    logic ack_seen = 1'b0;
    int   held = 0;
    int   load;
    for (int n = 0; n < 600; n++) begin
      load = (n < 300) ? 9 : 5;
      if (ack_seen) begin
        dbg_req = 1'b0;
      end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom); dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = $urandom;
      end
      cpu_valid = ($urandom_range(0, 9) < load);
      cpu_addr = 8'($urandom_range(0, 15)); cpu_wren = 4'($urandom); cpu_wdata = $urandom;
      #2;
      checks++;
      if (mem_addr !== exp_addr || mem_wren !== exp_wren || mem_wdata !== exp_wdata) begin
        failures++;
        $display("FAIL rand_port n=%0d got %h/%b/%h exp %h/%b/%h",
                 n, mem_addr, mem_wren, mem_wdata, exp_addr, exp_wren, exp_wdata);
      end
      checks++;
      if (dbg_ack !== m_ack || busy !== exp_busy || stall_req !== exp_stall) begin
        failures++;
        $display("FAIL rand_ctrl n=%0d got ack=%b busy=%b stall=%b exp %b/%b/%b",
                 n, dbg_ack, busy, stall_req, m_ack, exp_busy, exp_stall);
      end
      checks++;
      if (dbg_rdata !== m_rdata || cpu_rdata !== ref_mem[exp_addr]) begin
        failures++;
        $display("FAIL rand_data n=%0d got dbg=%h cpu=%h exp %h/%h",
                 n, dbg_rdata, cpu_rdata, m_rdata, ref_mem[exp_addr]);
      end
      if (dbg_ack === 1'b1)
        $display("rand txn n=%0d we=%b addr=%h rdata=%h", n, m_we, m_addr, dbg_rdata);
      ack_seen = dbg_ack;
      held = dbg_req ? held + 1 : 0;
      if (held > 200) begin
        checks++;
        failures++;
        $display("FAIL rand_timeout n=%0d got no ack after %0d cycles exp ack", n, held);
        break;
      end
      next_cycle();
    end
    dbg_req = 1'b0; cpu_valid = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = '0;
      for (int l = 0; l < 4; l++) bank[l][a] = 8'h00;
    end
    test_reset();
    test_idle_read();
    test_collision();
    test_starvation();
    test_dbg_write();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
